// File: rtl/mux_scan_pkg.sv
// Shared constants and width helper for the mux_scan block.
// Optional hold feature is enabled by defining MUX_SCAN_HOLD_EN.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Bits needed to encode values 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N-to-1 selector of W-bit channels packed in din.
// Selects beyond N-1 yield zero.
module mux_nto1
    import mux_scan_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4,
    localparam int CW = clog2(N)
) (
    input  logic [N*W-1:0] din,
    input  logic [CW-1:0]  sel,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == CW'(k)) begin
                y = din[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered channel selector with manual select and timed auto-scan.
// Define MUX_SCAN_HOLD_EN to add the hold input that freezes advance.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int DWELL = 50000000,
    localparam int CW   = clog2(N)
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic [N*W-1:0] din,
    input  logic [CW-1:0]  sel,
    input  logic           mode,
`ifdef MUX_SCAN_HOLD_EN
    input  logic           hold,
`endif
    output logic [W-1:0]   dout,
    output logic [CW-1:0]  ch,
    output logic           step
);

    localparam int CNTW = clog2(DWELL);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [CW-1:0]   CH_LAST  = CW'(N - 1);
    localparam logic [CW:0]     N_L      = (CW + 1)'(N);

    logic [CW-1:0]   r_ch;
    logic [CNTW-1:0] r_cnt;
    logic [W-1:0]    r_dout;
    logic            r_step;
    logic            r_mode_q;

    logic            w_hold;
    logic            w_rise;
    logic [CNTW-1:0] w_cnt_cur;
    logic [CNTW-1:0] w_cnt_n;
    logic [CW-1:0]   w_ch_n;
    logic [W-1:0]    w_y;

`ifdef MUX_SCAN_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // A fresh entry into auto mode starts a full dwell period.
    assign w_rise    = (mode == MODE_AUTO) & (r_mode_q == MODE_MANUAL);
    assign w_cnt_cur = w_rise ? '0 : r_cnt;

    always_comb begin
        w_ch_n  = r_ch;
        w_cnt_n = r_cnt;
        if (w_hold) begin
            w_ch_n  = r_ch;
            w_cnt_n = r_cnt;
        end else if (mode == MODE_AUTO) begin
            if (w_cnt_cur == CNT_LAST) begin
                w_cnt_n = '0;
                w_ch_n  = (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
            end else begin
                w_cnt_n = w_cnt_cur + 1'b1;
            end
        end else begin
            w_cnt_n = '0;
            if ({1'b0, sel} < N_L) begin
                w_ch_n = sel;
            end
        end
    end

    mux_nto1 #(
        .N (N),
        .W (W)
    ) u_mux (
        .din (din),
        .sel (w_ch_n),
        .y   (w_y)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_ch     <= '0;
            r_cnt    <= '0;
            r_dout   <= '0;
            r_step   <= 1'b0;
            r_mode_q <= MODE_MANUAL;
        end else begin
            r_ch     <= w_ch_n;
            r_cnt    <= w_cnt_n;
            r_dout   <= w_y;
            r_step   <= (w_ch_n != r_ch);
            r_mode_q <= mode;
        end
    end

    assign dout = r_dout;
    assign ch   = r_ch;
    assign step = r_step;

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan (N=4/W=4/DWELL=3 and N=3/DWELL=1).
// Hold checks run when MUX_SCAN_HOLD_EN is defined.
module tb_mux_scan;

    logic        Clock;
    logic        Resetn;
    logic [15:0] din;
    logic [1:0]  sel;
    logic        mode;
    logic        hold;
    logic [3:0]  dout;
    logic [1:0]  ch;
    logic        step;

    logic [11:0] din3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [3:0]  dout3;
    logic [1:0]  ch3;
    logic        step3;

    int n_tests;
    int n_fail;

    mux_scan #(.N(4), .W(4), .DWELL(3)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .din    (din),
        .sel    (sel),
        .mode   (mode),
`ifdef MUX_SCAN_HOLD_EN
        .hold   (hold),
`endif
        .dout   (dout),
        .ch     (ch),
        .step   (step)
    );

    mux_scan #(.N(3), .W(4), .DWELL(1)) dut3 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .din    (din3),
        .sel    (sel3),
        .mode   (mode3),
`ifdef MUX_SCAN_HOLD_EN
        .hold   (1'b0),
`endif
        .dout   (dout3),
        .ch     (ch3),
        .step   (step3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] prev;
        logic [1:0] seq [5];
        logic [15:0] d;
        n_tests = 0;
        n_fail  = 0;
        hold    = 1'b0;
        Resetn  = 1'b0;
        din     = 16'hDCBA;
        sel     = 2'd0;
        mode    = 1'b0;
        din3    = 12'hCBA;
        sel3    = 2'd0;
        mode3   = 1'b0;

        #3;
        chk("rst_ch", 32'(ch), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        tick();
        Resetn = 1'b1;

        // Manual select
        sel = 2'd2;
        tick();
        chk("man_dout", 32'(dout), 32'hC);
        chk("man_ch", 32'(ch), 32'd2);
        chk("man_step", 32'(step), 32'd1);
        tick();
        chk("man_step_hold", 32'(step), 32'd0);
        din = 16'hD5BA;
        tick();
        chk("man_track", 32'(dout), 32'h5);
        chk("man_track_step", 32'(step), 32'd0);
        sel = 2'd3;
        tick();
        chk("man_ch3", 32'(ch), 32'd3);
        chk("man_dout3", 32'(dout), 32'hD);

        // Auto scan with wrap from channel 3
        mode = 1'b1;
        sel  = 2'd1;
        seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        prev = 2'd3;
        d    = din;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("auto_wait1", 32'({ch, step}), 32'({prev, 1'b0}));
            tick();
            chk("auto_wait2", 32'({ch, step}), 32'({prev, 1'b0}));
            tick();
            chk("auto_adv", 32'({ch, step}), 32'({seq[i], 1'b1}));
            chk("auto_dout", 32'(dout), 32'(d[seq[i]*4 +: 4]));
            prev = seq[i];
        end

        // Mode switch at cnt=1, ch=1
        tick();
        tick();
        tick();
        chk("sw_ch1", 32'(ch), 32'd1);
        tick();
        mode = 1'b0;
        sel  = 2'd1;
        tick();
        chk("sw_man", 32'({ch, step}), 32'({2'd1, 1'b0}));
        mode = 1'b1;
        tick();
        tick();
        chk("sw_wait", 32'({ch, step}), 32'({2'd1, 1'b0}));
        tick();
        chk("sw_adv", 32'({ch, step}), 32'({2'd2, 1'b1}));
        chk("sw_dout", 32'(dout), 32'h5);

        // Asynchronous reset mid-scan
        Resetn = 1'b0;
        #1;
        chk("ar_ch", 32'(ch), 32'd0);
        chk("ar_dout", 32'(dout), 32'd0);
        chk("ar_step", 32'(step), 32'd0);
        tick();
        Resetn = 1'b1;
        tick();
        tick();
        chk("ar_full_dwell", 32'({ch, step}), 32'({2'd0, 1'b0}));
        tick();
        chk("ar_adv", 32'({ch, step}), 32'({2'd1, 1'b1}));
        chk("ar_dout_b", 32'(dout), 32'hB);

`ifdef MUX_SCAN_HOLD_EN
        tick();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_frz", 32'({ch, step}), 32'({2'd1, 1'b0}));
        end
        din = 16'hD57A;
        tick();
        chk("hold_dout", 32'(dout), 32'h7);
        hold = 1'b0;
        tick();
        chk("hold_rel1", 32'({ch, step}), 32'({2'd1, 1'b0}));
        tick();
        chk("hold_rel2", 32'({ch, step}), 32'({2'd2, 1'b1}));
`endif

        // N=3, DWELL=1 instance: out-of-range select and every-cycle scan
        sel3 = 2'd1;
        tick();
        chk("n3_ch1", 32'(ch3), 32'd1);
        chk("n3_dout", 32'(dout3), 32'hB);
        sel3 = 2'd3;
        tick();
        chk("oor_ch", 32'({ch3, step3}), 32'({2'd1, 1'b0}));
        din3 = 12'hC7A;
        tick();
        chk("oor_dout", 32'(dout3), 32'h7);
        chk("oor_ch2", 32'(ch3), 32'd1);
        mode3 = 1'b1;
        tick();
        chk("d1_a", 32'({ch3, step3}), 32'({2'd2, 1'b1}));
        tick();
        chk("d1_b", 32'({ch3, step3}), 32'({2'd0, 1'b1}));
        chk("d1_dout", 32'(dout3), 32'hA);
        tick();
        chk("d1_c", 32'({ch3, step3}), 32'({2'd1, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter W, default 4, data width per channel (legal 1..32).
REQ-003 SHALL have parameter DWELL, default 50000000, clock cycles per channel in auto mode (legal >=1).
REQ-004 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port din  input  N*W  packed channels, channel k at bits [k*W+W-1 : k*W].
REQ-007 SHALL have port sel  input  CW  manual channel select, where CW = clog2(N).
REQ-008 SHALL have port mode  input  1  0 = manual, 1 = auto-scan.
REQ-009 SHALL have port hold  input  1  freeze channel advance; present only when the macro in REQ-024 is defined.
REQ-010 SHALL have port dout  output  W  registered selected channel data.
REQ-011 SHALL have port ch  output  CW  registered current channel index.
REQ-012 SHALL have port step  output  1  one-cycle pulse when ch changes value.

Function
REQ-013 SHALL compute next channel ch_n each cycle, and register ch <= ch_n and dout <= din[ch_n] on the same edge, giving 1-cycle latency from sel/din to dout.
REQ-014 In manual mode, ch_n SHALL equal sel when sel <= N-1; for sel >= N, ch_n SHALL equal ch (out-of-range select ignored, no wrap).
REQ-015 In auto mode, dwell counter cnt SHALL count 0..DWELL-1; at cnt == DWELL-1, cnt SHALL become 0 and ch_n SHALL be ch+1, or 0 when ch == N-1; otherwise ch_n = ch.
REQ-016 sel SHALL be ignored in auto mode.
REQ-017 On a 0->1 mode transition (sampled), cnt SHALL restart at 0 and scanning SHALL continue from the current ch.
REQ-018 In manual mode, cnt SHALL be held at 0; on a 1->0 transition, ch SHALL take sel at the next edge per REQ-014.
REQ-019 step SHALL be registered and SHALL be 1 for exactly the cycle after an edge where ch_n != ch, and 0 otherwise; a manual sel equal to ch SHALL NOT pulse step.
REQ-020 With DWELL = 1, auto mode SHALL advance ch every cycle and step SHALL stay 1 continuously.
REQ-021 dout SHALL track din of the current channel every cycle even when ch does not change.

Reset
REQ-022 While Resetn = 0, the block SHALL asynchronously force ch = 0, dout = 0, cnt = 0, step = 0, and the mode-edge register = 0.
REQ-023 On release of Resetn mid-scan, the block SHALL restart from channel 0 with a full DWELL period; no pre-reset state SHALL survive.

Configuration
REQ-024 Macro MUX_SCAN_HOLD_EN defined: hold = 1 SHALL freeze ch and cnt in both modes, and step SHALL be 0; dout SHALL still follow din[ch]; releasing hold SHALL resume counting from the frozen cnt.
REQ-025 Macro MUX_SCAN_HOLD_EN undefined: port hold SHALL be absent, and behaviour SHALL be identical to hold = 0.

Structure
REQ-026 Shared package mux_scan_pkg SHALL hold the mode encoding constants (MODE_MANUAL = 0, MODE_AUTO = 1) and the clog2 width helper used for CW.
REQ-027 The combinational N-to-1, W-bit selector SHALL be sub-module mux_nto1 (parameters N, W; ports din, sel, y), instantiated once to produce din[ch_n].
REQ-028 Counter, mode-edge detect, and output registers SHALL reside in mux_scan; the RTL SHALL be about 120-250 lines total.

Verification (N=4, W=4, DWELL=3 unless stated)
REQ-029 Reset: Resetn = 0 mid-scan with ch = 2 -> ch = 0, dout = 0, step = 0 immediately, without a clock edge.
REQ-030 Manual: din = 16'hDCBA, sel = 2 -> dout = 4'hC and step = 1 after 1 edge; sel held -> step = 0 the next cycle.
REQ-031 Auto wrap: mode = 1 from ch = 3 -> ch = 0 after 3 edges with a step pulse, then 1, 2, 3, 0 at 3-cycle intervals.
REQ-032 Mode switch: auto at cnt = 1, ch = 1; mode = 0 with sel = 1 -> ch stays 1, no step; mode = 1 again -> next advance after 3 edges.
REQ-033 Out-of-range: N = 3, sel = 3 in manual mode with ch = 1 -> ch stays 1, no step, and dout follows din channel 1.
REQ-034 Hold (MUX_SCAN_HOLD_EN defined): auto mode, hold = 1 for 10 cycles -> ch frozen and step = 0; change din[ch] -> dout updates 1 cycle later; release hold -> advance after the remaining dwell cycles.
